// File: rtl/arb_request_issuer_pkg.sv
// ============================================================================
// Module      : arb_request_issuer_pkg
// Description : Shared widths, channel index type and grant-check helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package arb_request_issuer_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int NUM_CH         = 2;

  typedef logic ch_idx_t;

  // Both grants at once, or a grant on a line that is not requesting.
  function automatic logic grant_violation(input logic [1:0] gnt, input logic [1:0] req);
    return (gnt == 2'b11) | (|(gnt & ~req));
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_req_fifo.sv
// ============================================================================
// Module      : arb_req_fifo
// Description : Per-channel job queue with wrap-around pointers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module arb_req_fifo
  import arb_request_issuer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              ready_o,
  output logic              nonempty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              w_push;
  logic              w_pop;

  assign ready_o    = (count_q < CNT_W'(DEPTH));
  assign nonempty_o = (count_q != '0);
  assign head_o     = mem_q[rd_ptr_q];
  assign w_push     = push_i & ready_o;
  assign w_pop      = pop_i & nonempty_o;

  // DEPTH is a power of two, so pointer increment wraps on its own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/arb_request_issuer.sv
// ============================================================================
// Module      : arb_request_issuer
// Description : Two-channel job queues feeding an external arbiter and a
//               single output register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module arb_request_issuer
  import arb_request_issuer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        in_valid_i,
  input  logic [DATA_W-1:0] in_data0_i,
  input  logic [DATA_W-1:0] in_data1_i,
  output logic [1:0]        in_ready_o,
  output logic [1:0]        requests_o,
  input  logic [1:0]        grants_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output ch_idx_t           out_src_o,
  input  logic              out_ready_i,
  output logic              proto_err_o
);

  logic [DATA_W-1:0] w_in_data [NUM_CH];
  logic [DATA_W-1:0] w_head    [NUM_CH];
  logic [1:0]        w_nonempty;
  logic [1:0]        w_pop;
  logic              w_slot_free;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  ch_idx_t           out_src_q,   out_src_d;
  logic              proto_err_q, proto_err_d;

  assign w_in_data[0] = in_data0_i;
  assign w_in_data[1] = in_data1_i;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    arb_req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (in_valid_i[i]),
      .data_i     (w_in_data[i]),
      .pop_i      (w_pop[i]),
      .ready_o    (in_ready_o[i]),
      .nonempty_o (w_nonempty[i]),
      .head_o     (w_head[i])
    );
  end

  assign w_slot_free = ~out_valid_q | out_ready_i;
  assign requests_o  = w_nonempty & {2{w_slot_free}};

  // Only a clean one-hot grant on a requesting line pops.
  assign w_pop[0] = (grants_i == 2'b01) & requests_o[0];
  assign w_pop[1] = (grants_i == 2'b10) & requests_o[1];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    proto_err_d = proto_err_q | grant_violation(grants_i, requests_o);
    if (|w_pop) begin
      out_valid_d = 1'b1;
      out_data_d  = w_pop[1] ? w_head[1] : w_head[0];
      out_src_d   = w_pop[1];
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign proto_err_o = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_request_issuer.sv
// ============================================================================
// Module      : tb_arb_request_issuer
// Description : Directed vector table plus reset, round-robin and
//               grant-error sequences for arb_request_issuer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_arb_request_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_valid;
  logic [7:0] in_data0, in_data1;
  logic [1:0] in_ready;
  logic [1:0] requests;
  logic [1:0] grants;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_ready;
  logic       proto_err;

  logic       mode_rr;
  logic [1:0] gnt_man;
  logic       rr_last;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arb_request_issuer #(.DATA_W(8), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_data0_i  (in_data0),
    .in_data1_i  (in_data1),
    .in_ready_o  (in_ready),
    .requests_o  (requests),
    .grants_i    (grants),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_src_o   (out_src),
    .out_ready_i (out_ready),
    .proto_err_o (proto_err)
  );

  // Round-robin arbiter model: on contention favour the channel not served last.
  always_comb begin
    if (!mode_rr)              grants = gnt_man;
    else if (requests == 2'b11) grants = rr_last ? 2'b01 : 2'b10;
    else                       grants = requests;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_last <= 1'b1;
    else if (grants == 2'b01 && requests[0]) rr_last <= 1'b0;
    else if (grants == 2'b10 && requests[1]) rr_last <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] vin;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ordy;
    logic [1:0] gnt;
    logic [1:0] req;
    logic [1:0] inrdy;
    logic       ov;
    logic [7:0] od;
    logic       os;
    logic       err;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] got_d [4];
    logic       got_s [4];
    int         nq;
    logic [7:0] exp_d [4];
    logic [1:0] exp_s;

    //           vin    d0     d1     ordy  gnt    req    inrdy  ov    od     os    err
    vecs[0]  = '{2'b01, 8'h11, 8'h00, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 8'h22, 8'h00, 1'b0, 2'b01, 2'b01, 2'b11, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b01, 2'b11, 1'b1, 8'h22, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 2'b11, 1'b0, 8'h22, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 8'h00, 8'hB0, 1'b1, 2'b00, 2'b00, 2'b11, 1'b0, 8'h22, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 8'h00, 8'hB1, 1'b1, 2'b00, 2'b10, 2'b11, 1'b0, 8'h22, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 8'h00, 8'hB2, 1'b1, 2'b00, 2'b10, 2'b01, 1'b0, 8'h22, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b10, 2'b01, 1'b1, 8'hB0, 1'b1, 1'b0};
    vecs[10] = '{2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 8'hB0, 1'b1, 1'b0};
    vecs[11] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b10, 2'b11, 1'b1, 8'hB1, 1'b1, 1'b0};
    vecs[12] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 2'b11, 1'b0, 8'hB1, 1'b1, 1'b0};
    vecs[13] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b00, 2'b11, 1'b0, 8'hB1, 1'b1, 1'b1};
    vecs[14] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 2'b11, 1'b0, 8'hB1, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 2'b00; in_data0 = '0; in_data1 = '0;
    out_ready = 1'b0; mode_rr = 1'b0; gnt_man = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_requests",  32'(requests),  32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h3);
    check("rst_proto_err", 32'(proto_err), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // ---------------- vector table ----------------
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid = vecs[i].vin; in_data0 = vecs[i].d0; in_data1 = vecs[i].d1;
      out_ready = vecs[i].ordy; gnt_man = vecs[i].gnt;
      #2;
      check($sformatf("v%0d_requests", i), 32'(requests), 32'(vecs[i].req));
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].inrdy));
      @(posedge clk); #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      check($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].od));
      check($sformatf("v%0d_out_src", i),   32'(out_src),   32'(vecs[i].os));
      check($sformatf("v%0d_proto_err", i), 32'(proto_err), 32'(vecs[i].err));
    end

    // ---------------- round-robin contention ----------------
    @(negedge clk); rst_n = 1'b0; in_valid = 2'b00; gnt_man = 2'b00;
    @(negedge clk); rst_n = 1'b1; mode_rr = 1'b1; out_ready = 1'b1;
    nq = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      case (c)
        0:       begin in_valid = 2'b11; in_data0 = 8'hA0; in_data1 = 8'hB0; end
        1:       begin in_valid = 2'b11; in_data0 = 8'hA1; in_data1 = 8'hB1; end
        default: in_valid = 2'b00;
      endcase
      @(posedge clk); #1;
      if (out_valid && nq < 4) begin
        got_d[nq] = out_data;
        got_s[nq] = out_src;
        nq++;
      end
    end
    exp_d[0] = 8'hA0; exp_d[1] = 8'hB0; exp_d[2] = 8'hA1; exp_d[3] = 8'hB1;
    check("rr_job_count", 32'(nq), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < nq) begin
        exp_s = 2'(k % 2);
        check($sformatf("rr_data%0d", k), 32'(got_d[k]), 32'(exp_d[k]));
        check($sformatf("rr_src%0d", k),  32'(got_s[k]), 32'(exp_s[0]));
      end
    end
    mode_rr = 1'b0;

    // ---------------- asynchronous reset mid-stream ----------------
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    in_valid = 2'b11; in_data0 = 8'hC0; in_data1 = 8'hD0; gnt_man = 2'b00; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 2'b01; in_data0 = 8'hC1; gnt_man = 2'b01;
    #2;
    check("mid_requests_pre", 32'(requests), 32'h3);
    @(negedge clk);
    in_valid = 2'b00; gnt_man = 2'b00;
    #1;
    check("mid_out_valid_pre", 32'(out_valid), 32'h1);
    check("mid_out_data_pre",  32'(out_data),  32'hC0);
    check("mid_requests_held", 32'(requests),  32'h3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_requests",  32'(requests),  32'h0);
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    check("mid_rst_in_ready",  32'(in_ready),  32'h3);
    check("mid_rst_out_data",  32'(out_data),  32'h0);
    @(negedge clk); rst_n = 1'b1;

    // ---------------- double grant protocol error ----------------
    @(negedge clk);
    in_valid = 2'b11; in_data0 = 8'hE0; in_data1 = 8'hF0; gnt_man = 2'b00; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 2'b00; gnt_man = 2'b11;
    #2;
    check("err_requests_pre", 32'(requests), 32'h3);
    @(posedge clk); #1;
    check("err_out_valid", 32'(out_valid), 32'h0);
    check("err_flag",      32'(proto_err), 32'h1);
    @(negedge clk); gnt_man = 2'b00;
    #2;
    check("err_requests_kept", 32'(requests), 32'h3);
    repeat (3) @(posedge clk);
    #1;
    check("err_flag_sticky", 32'(proto_err), 32'h1);
    @(negedge clk); gnt_man = 2'b10;
    @(posedge clk); #1;
    check("err_pop_data", 32'(out_data), 32'hF0);
    check("err_pop_src",  32'(out_src),  32'h1);
    @(negedge clk); gnt_man = 2'b00; rst_n = 1'b0;
    #1;
    check("err_cleared_by_reset", 32'(proto_err), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arb_request_issuer.md
ARB_REQUEST_ISSUER -- requirements
Module: arb_request_issuer

Interface
REQ-001 Parameter DATA_W, 8, payload width per job.
REQ-002 Parameter DEPTH, 2, per-channel queue depth; power of 2, >= 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  2  job offered on channel i.
REQ-006 in_data0, in_data1  input  DATA_W each  payload for channel 0 / 1.
REQ-007 in_ready  output  2  channel i queue can accept a job.
REQ-008 requests  output  2  request lines to the round-robin arbiter.
REQ-009 grants  input  2  grant lines from the arbiter, combinational from requests within the same cycle.
REQ-010 out_valid  output  1  job held in output register.
REQ-011 out_data  output  DATA_W  payload of the held job.
REQ-012 out_src  output  1  channel that supplied the held job.
REQ-013 out_ready  input  1  downstream accepts the held job.
REQ-014 proto_err  output  1  sticky arbiter-protocol violation flag.

Function
REQ-015 Each channel SHALL own a DEPTH-entry FIFO with wrap-around pointers and a count of width $clog2(DEPTH)+1.
REQ-016 in_ready[i] SHALL be 1 iff count_i < DEPTH; a push occurs when in_valid[i] & in_ready[i].
REQ-017 A push into a full queue SHALL not occur (in_ready low); a simultaneous push and pop on a full queue is not permitted (in_ready stays low when full).
REQ-018 slot_free SHALL equal ~out_valid | out_ready.
REQ-019 requests[i] SHALL equal (count_i != 0) & slot_free; no other term.
REQ-020 A pop of channel i SHALL occur iff grants == one-hot i and requests[i] == 1 in that cycle.
REQ-021 On a pop, the head entry SHALL load into out_data, out_src SHALL load i, and out_valid SHALL be 1 the next cycle: one-cycle latency from grant to out_valid.
REQ-022 If out_valid & out_ready and no pop occurs, out_valid SHALL clear next cycle; with a pop in the same cycle it SHALL stay 1 with new data, giving back-to-back throughput of one job per cycle.
REQ-023 Simultaneous push and pop on a non-full queue SHALL leave count unchanged, with both pointers advancing.
REQ-024 grants == 2'b11, or a grant bit set while the matching request is 0, SHALL cause no pop and SHALL set proto_err, which stays 1 until reset.
REQ-025 When the queue is empty or slot_free is 0, grants == 2'b00 SHALL cause no pop and no state change.
REQ-026 The block SHALL NOT reorder jobs within a channel; cross-channel order is set solely by grants.

Reset
REQ-027 While rst_n == 0, the block SHALL hold: both counts and pointers 0, out_valid 0, out_data 0, out_src 0, proto_err 0, requests 2'b00, in_ready 2'b11.
REQ-028 Reset asserted mid-transfer SHALL discard all queued and held jobs immediately, without waiting for a clock edge.
REQ-029 Queue storage arrays SHALL need no reset; only valid-tracking state is reset.

Structure
REQ-030 A shared package SHALL hold a default DATA_W localparam and the channel-index type (1-bit).
REQ-031 The per-channel queue SHALL be one sub-module, arb_req_fifo, instantiated twice; the output register and request/grant logic stay in the top.

Verification
REQ-032 Reset: rst_n low mid-stream with both queues at count 1 -> requests 00, out_valid 0, in_ready 11 in the same cycle.
REQ-033 Single channel: push 0x11, 0x22 on ch0, arbiter grants 01 whenever requested -> out_data 0x11 then 0x22, out_src 0, one cycle after each grant.
REQ-034 Contention with the round-robin arbiter attached: ch0 holds {0xA0,0xA1}, ch1 holds {0xB0,0xB1}, out_ready 1 -> output sequence A0, B0, A1, B1.
REQ-035 Backpressure: out_ready 0 with out_valid 1 -> requests 00, out_data stable; out_ready raised -> the next job follows with no bubble.
REQ-036 Full queue: DEPTH pushes on ch1 with no grants -> in_ready[1] 0; a third in_valid is ignored; one grant -> in_ready[1] returns to 1.
REQ-037 Protocol error: force grants 11 with both requests set -> no pop, counts unchanged, proto_err 1 and held until rst_n low.
